vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Sequences the single VRAM port (24-bit address, 8-bit data) between two requesters: the raster fetch path (text/bitmap generators) and the CPU register/VRAM window.
- Video has fixed priority. CPU accesses are serialised with a four-phase req/ack handshake and are never aborted once started.
- Sits between the video controller's address/data muxing and the external VRAM pins.

Parameters:
- MEM_WAIT, 1, wait cycles between address presented and mem_rdata valid (1..15).
- STREAK_MAX, 8, consecutive video grants before a forced CPU slot (used only with the optional feature).

Ports:
- clk_main  in  1  system clock; all logic on rising edge.
- reset_in  in  1  reset; synchronous, active-high.
- vid_req  in  1  video fetch request; held high until vid_valid.
- vid_addr  in  24  video fetch address.
- vid_data  out  8  fetched byte.
- vid_valid  out  1  one-cycle pulse, vid_data valid.
- cpu_req  in  1  CPU request (four-phase).
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  24  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  24  VRAM address.
- mem_wdata  out  8  VRAM write data.
- mem_rdata  in  8  VRAM read data.
- mem_cs  out  1  chip select.
- mem_oe  out  1  output enable (reads).
- mem_we  out  1  write enable.

Behaviour:
- Reset (synchronous): state IDLE. mem_cs/oe/we=0, mem_addr=0, mem_wdata=0, vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, cpu_done=0, wait counter=0, streak=0.
- Reset asserted mid-access forces IDLE on the next edge and drops mem_cs the same edge; the in-flight access produces no ack or valid pulse.
- IDLE: mem_cs=0.
  - vid_req=1 -> VID_ACC.
  - Else cpu_req=1 and cpu_done=0 -> CPU_ACC.
  - Entering either state latches the address (and for CPU: rw, wdata) into mem_addr/mem_wdata and loads the counter with MEM_WAIT.
- VID_ACC: mem_cs=1, mem_oe=1, mem_we=0. Counter decrements each cycle.
  - When counter==0: vid_data<=mem_rdata, vid_valid<=1 for the next cycle.
  - Next state follows the IDLE rules evaluated in the same cycle (back-to-back video allowed, no idle bubble).
  - Access length = MEM_WAIT+1 cycles.
- CPU_ACC: mem_cs=1; mem_oe=cpu_rw, mem_we=~cpu_rw (latched values), held for the whole access.
  - When counter==0: for reads, cpu_rdata<=mem_rdata. cpu_ack<=1 for one cycle, cpu_done<=1, next state by the IDLE rules with the CPU excluded.
- cpu_done clears on the cycle cpu_req is sampled low. No new CPU grant occurs while cpu_done=1. cpu_req may drop at any point after ack.
- Simultaneous vid_req and cpu_req in IDLE: video wins.
- A CPU access in progress is never preempted. Worst-case video latency from vid_req to vid_valid = 2*(MEM_WAIT+1)+1 cycles.
- mem_addr/mem_wdata keep the last value between accesses (no tri-state).
- cpu_ack and vid_valid never assert in the same cycle.

Optional Feature:
- Macro VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - streak counter, width clog2(STREAK_MAX+1), increments on every VID_ACC grant and clears on any CPU grant or any IDLE cycle with no grant.
  - When streak==STREAK_MAX and cpu_req=1, cpu_done=0, the CPU wins the next arbitration even if vid_req=1; streak then clears.
- Undefined: no counter; strict video priority, and the CPU can starve indefinitely under continuous vid_req.

Test Plan:
- MEM_WAIT=1, vid_req=1 with vid_addr=0x000123, mem_rdata=0x5A -> mem_cs high 2 cycles, mem_addr=0x000123, vid_valid pulse, vid_data=0x5A.
- CPU write: cpu_addr=0x00F000, cpu_wdata=0xC3, cpu_rw=0 -> mem_we high 2 cycles with that addr/data, cpu_ack one pulse. Holding cpu_req high 5 more cycles yields no second access.
- vid_req and cpu_req (read, 0x000010) rise in the same cycle -> video access first, then CPU access back-to-back, cpu_rdata=mem_rdata at ack.
- CPU access in progress, vid_req rises in its first cycle -> CPU completes unaborted, video grant next cycle, vid_valid 5 cycles after vid_req.
- reset_in pulsed during cycle 1 of a CPU read -> mem_cs=0 next edge, no cpu_ack, all outputs at reset values.
- With VRAM_ARB_STARVE_GUARD_EN, STREAK_MAX=8, vid_req held high, cpu_req=1 -> exactly 8 video accesses, then 1 CPU access, then video resumes. Without the macro -> cpu_ack never asserts.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between the raster fetch path
// (fixed priority) and the CPU window (four-phase req/ack handshake).
// Optional build macro VRAM_ARB_STARVE_GUARD_EN adds a video-streak counter
// that forces a CPU slot after STREAK_MAX consecutive video grants.
module vram_arbiter #(
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned STREAK_MAX = 8
) (
    input  logic        clk_main,
    input  logic        reset_in,
    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VID_ACC = 2'd1,
        CPU_ACC = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        mem_cs_q;
    logic        mem_oe_q;
    logic        mem_we_q;
    logic [7:0]  vid_data_q;
    logic        vid_valid_q;
    logic [7:0]  cpu_rdata_q;
    logic        cpu_ack_q;
    logic        cpu_done_q;

    logic        acc_end;
    logic        arb_point;
    logic        cpu_elig;
    logic        force_cpu;
    logic        grant_vid;
    logic        grant_cpu;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned   SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    logic [SW-1:0] streak_q;
`endif

    // Arbitration: evaluated in IDLE and on the last cycle of any access so
    // consecutive accesses run without an idle bubble.
    always_comb begin
        acc_end   = (state_q != IDLE) && (cnt_q == '0);
        arb_point = (state_q == IDLE) || acc_end;
        // The CPU is never granted twice in a row for one handshake.
        cpu_elig  = cpu_req && !cpu_done_q && (state_q != CPU_ACC);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        force_cpu = cpu_elig && (streak_q == STREAK_LIM);
`else
        // STREAK_MAX only has an effect when the starvation guard is built.
        force_cpu = 1'b0 & (STREAK_MAX != 0);
`endif
        grant_vid = arb_point && vid_req && !force_cpu;
        grant_cpu = arb_point && cpu_elig && (!vid_req || force_cpu);
    end

    // Access sequencer: state, wait counter, VRAM strobes and result registers.
    always_ff @(posedge clk_main) begin
        if (reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
            streak_q    <= '0;
`endif
        end else begin
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;

            if (!cpu_req) begin
                cpu_done_q <= 1'b0;
            end

            if ((state_q != IDLE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (acc_end) begin
                if (state_q == VID_ACC) begin
                    vid_data_q  <= mem_rdata;
                    vid_valid_q <= 1'b1;
                end else begin
                    if (mem_oe_q) begin
                        cpu_rdata_q <= mem_rdata;
                    end
                    cpu_ack_q  <= 1'b1;
                    cpu_done_q <= 1'b1;
                end
            end

            if (grant_vid) begin
                state_q    <= VID_ACC;
                cnt_q      <= WAIT_LOAD;
                mem_addr_q <= vid_addr;
                mem_cs_q   <= 1'b1;
                mem_oe_q   <= 1'b1;
                mem_we_q   <= 1'b0;
            end else if (grant_cpu) begin
                state_q     <= CPU_ACC;
                cnt_q       <= WAIT_LOAD;
                mem_addr_q  <= cpu_addr;
                mem_wdata_q <= cpu_wdata;
                mem_cs_q    <= 1'b1;
                mem_oe_q    <= cpu_rw;
                mem_we_q    <= ~cpu_rw;
            end else if (arb_point) begin
                state_q  <= IDLE;
                mem_cs_q <= 1'b0;
                mem_oe_q <= 1'b0;
                mem_we_q <= 1'b0;
            end

`ifdef VRAM_ARB_STARVE_GUARD_EN
            // Saturates at the limit so a lone video stream never wraps it.
            if (grant_vid) begin
                if (streak_q != STREAK_LIM) begin
                    streak_q <= streak_q + SW'(1);
                end
            end else if (grant_cpu || (state_q == IDLE)) begin
                streak_q <= '0;
            end
`endif
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by two concurrent
// random requesters checked against a byte-array model of VRAM contents.
module tb_vram_arbiter;

    localparam int unsigned MW   = 1;
    localparam int unsigned SMAX = 8;

    logic        clk_main = 1'b0;
    logic        reset_in;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_rw;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;

    always #5 clk_main = ~clk_main;

    vram_arbiter #(
        .MEM_WAIT  (MW),
        .STREAK_MAX(SMAX)
    ) dut (
        .clk_main (clk_main),
        .reset_in (reset_in),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_data (vid_data),
        .vid_valid(vid_valid),
        .cpu_req  (cpu_req),
        .cpu_rw   (cpu_rw),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we)
    );

    // External VRAM device: 256 bytes indexed by the low address byte.
    logic [7:0] vram [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    always @(posedge clk_main) begin
        if (bd_we) vram[bd_addr] <= bd_data;
        else if (mem_cs && mem_we) vram[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = vram[mem_addr[7:0]];

    // Expected VRAM contents as seen by the requesters.
    logic [7:0] ref_mem [256];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit stop_mon = 1'b0;

    // Per-window observations.
    int          w_cs, w_we, w_valid, w_ack, w_vfirst, w_afirst, w_vbefore;
    logic [7:0]  w_vdata, w_rdata, w_wedata;
    logic [23:0] w_addr0, w_weaddr;

    function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_main);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk_main);
        bd_we   = 1'b0;
    endtask

    // Observe n cycles; optionally drop vid_req once its access is seen.
    task automatic window(input int n, input bit drop_vid);
        w_cs = 0; w_we = 0; w_valid = 0; w_ack = 0;
        w_vfirst = -1; w_afirst = -1; w_vbefore = 0;
        w_vdata = '0; w_rdata = '0; w_wedata = '0; w_addr0 = '0; w_weaddr = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_main);
            if (mem_cs) begin
                if (w_cs == 0) w_addr0 = mem_addr;
                w_cs++;
            end
            if (mem_cs && mem_we) begin
                w_we++;
                w_weaddr = mem_addr;
                w_wedata = mem_wdata;
            end
            if (vid_valid) begin
                if (w_vfirst < 0) w_vfirst = i;
                if (w_afirst < 0) w_vbefore++;
                w_valid++;
                w_vdata = vid_data;
            end
            if (cpu_ack) begin
                if (w_afirst < 0) w_afirst = i;
                w_ack++;
                w_rdata = cpu_rdata;
            end
            if (drop_vid && vid_req && mem_cs && mem_oe && (mem_addr == vid_addr))
                vid_req = 1'b0;
        end
    endtask

    // Random video requester: reads the upper half of VRAM only.
    task automatic vid_proc();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            logic [23:0] a;
            bit          got;
            tick($urandom_range(3, 0));
            r = $urandom;
            a = r[23:0];
            a[7] = 1'b1;
            vid_addr = a;
            vid_req  = 1'b1;
            got      = 1'b0;
            for (int c = 1; c <= 4 * (MW + 1) + 6 && !got; c++) begin
                @(negedge clk_main);
                if (vid_req && mem_cs && mem_oe && (mem_addr == a)) vid_req = 1'b0;
                if (vid_valid) begin
                    got = 1'b1;
                    check("rnd_vid_data", 64'(vid_data), 64'(ref_mem[a[7:0]]));
`ifndef VRAM_ARB_STARVE_GUARD_EN
                    check("rnd_vid_latency", 64'(c <= 2 * (MW + 1)), 64'd1);
`endif
                end
            end
            if (!got) check("rnd_vid_timeout", 64'(got), 64'd1);
            vid_req = 1'b0;
        end
    endtask

    // Random CPU requester: reads/writes the lower half of VRAM only.
    task automatic cpu_proc();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            logic [23:0] a;
            logic [7:0]  wd;
            bit          rw;
            bit          got;
            tick($urandom_range(3, 0));
            r  = $urandom;
            a  = r[23:0];
            a[7] = 1'b0;
            r  = $urandom;
            wd = r[7:0];
            rw = r[8];
            cpu_addr  = a;
            cpu_wdata = wd;
            cpu_rw    = rw;
            cpu_req   = 1'b1;
            got       = 1'b0;
            for (int c = 1; c <= 4 * (MW + 1) + 8 && !got; c++) begin
                @(negedge clk_main);
                if (cpu_ack) begin
                    got = 1'b1;
                    if (rw) begin
                        check("rnd_cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[a[7:0]]));
                    end else begin
                        ref_mem[a[7:0]] = wd;
                        check("rnd_cpu_write", 64'(vram[a[7:0]]), 64'(wd));
                    end
                end
            end
            if (!got) check("rnd_cpu_timeout", 64'(got), 64'd1);
            cpu_req = 1'b0;
            @(negedge clk_main);
        end
    endtask

    initial begin
        reset_in  = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        fork
            while (!stop_mon) begin
                @(negedge clk_main);
                if (mon_en) begin
                    check("ack_valid_exclusive", 64'(cpu_ack & vid_valid), 64'd0);
                    check("strobe_consistency",
                          64'(mem_cs ? (mem_oe ^ mem_we) : !(mem_oe | mem_we)), 64'd1);
                end
            end
        join_none

        tick(3);
        check("reset_mem_strobes", 64'({mem_cs, mem_oe, mem_we}), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        check("reset_results", 64'({vid_data, vid_valid, cpu_rdata, cpu_ack}), 64'd0);

        poke(8'h23, 8'h5A);
        poke(8'h10, 8'h77);
        poke(8'h45, 8'h91);
        poke(8'h20, 8'h3C);
        poke(8'h30, 8'h4B);
        poke(8'h50, 8'h66);
        poke(8'h60, 8'hE1);
        reset_in = 1'b0;
        mon_en   = 1'b1;
        tick(1);

        // Single video fetch.
        vid_addr = 24'h000123;
        vid_req  = 1'b1;
        window(6, 1'b1);
        check("t1_cs_cycles", 64'(w_cs), 64'(MW + 1));
        check("t1_addr", 64'(w_addr0), 64'h000123);
        check("t1_valid_count", 64'(w_valid), 64'd1);
        check("t1_valid_cycle", 64'(w_vfirst), 64'(MW + 1));
        check("t1_vid_data", 64'(w_vdata), 64'h5A);
        tick(2);

        // CPU write with cpu_req held high well past the ack.
        cpu_rw    = 1'b0;
        cpu_addr  = 24'h00F000;
        cpu_wdata = 8'hC3;
        cpu_req   = 1'b1;
        window(MW + 1 + 6, 1'b0);
        check("t2_we_cycles", 64'(w_we), 64'(MW + 1));
        check("t2_cs_cycles", 64'(w_cs), 64'(MW + 1));
        check("t2_we_addr", 64'(w_weaddr), 64'h00F000);
        check("t2_we_data", 64'(w_wedata), 64'hC3);
        check("t2_ack_count", 64'(w_ack), 64'd1);
        check("t2_ack_cycle", 64'(w_afirst), 64'(MW + 1));
        cpu_req = 1'b0;
        tick(2);

        // Simultaneous requests: video first, CPU read back-to-back.
        cpu_wdata = 8'h00;
        cpu_rw    = 1'b1;
        cpu_addr  = 24'h000010;
        vid_addr  = 24'h000045;
        vid_req   = 1'b1;
        cpu_req   = 1'b1;
        window(10, 1'b1);
        check("t3_first_addr", 64'(w_addr0), 64'h000045);
        check("t3_valid_cycle", 64'(w_vfirst), 64'(MW + 1));
        check("t3_ack_cycle", 64'(w_afirst), 64'(2 * MW + 2));
        check("t3_cs_cycles", 64'(w_cs), 64'(2 * (MW + 1)));
        check("t3_vid_data", 64'(w_vdata), 64'h91);
        check("t3_cpu_rdata", 64'(w_rdata), 64'h77);
        cpu_req = 1'b0;
        tick(2);

        // Video arrives during the first cycle of a CPU read.
        cpu_addr = 24'h000020;
        cpu_req  = 1'b1;
        tick(1);
        check("t4_cpu_strobes", 64'({mem_cs, mem_oe, mem_we}), 64'b110);
        vid_addr = 24'h000045;
        vid_req  = 1'b1;
        window(10, 1'b1);
        check("t4_ack_cycle", 64'(w_afirst), 64'(MW));
        check("t4_cpu_rdata", 64'(w_rdata), 64'h3C);
        check("t4_valid_cycle", 64'(w_vfirst), 64'(2 * MW + 1));
        check("t4_vid_data", 64'(w_vdata), 64'h91);
        check("t4_counts", 64'({w_ack[7:0], w_valid[7:0]}), 64'h0101);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick(2);

        // Reset in the first cycle of a CPU read.
        cpu_addr  = 24'h000030;
        cpu_wdata = 8'hAA;
        cpu_req   = 1'b1;
        tick(1);
        check("t5_cs_before", 64'({mem_cs, mem_wdata}), 64'h1AA);
        reset_in = 1'b1;
        cpu_req  = 1'b0;
        tick(1);
        check("t5_reset_strobes", 64'({mem_cs, mem_oe, mem_we}), 64'd0);
        check("t5_reset_mem", 64'({mem_addr, mem_wdata}), 64'd0);
        check("t5_reset_results", 64'({vid_data, vid_valid, cpu_rdata, cpu_ack}), 64'd0);
        reset_in = 1'b0;
        window(6, 1'b0);
        check("t5_no_activity", 64'({w_ack[7:0], w_cs[7:0], w_valid[7:0]}), 64'd0);

        // Continuous video with a pending CPU read.
        vid_addr = 24'h000050;
        vid_req  = 1'b1;
        cpu_rw   = 1'b1;
        cpu_addr = 24'h000060;
        cpu_req  = 1'b1;
        window((MW + 1) * (SMAX + 4) + 4, 1'b0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check("t6_video_before_cpu", 64'(w_vbefore), 64'(SMAX));
        check("t6_ack_count", 64'(w_ack), 64'd1);
        check("t6_ack_cycle", 64'(w_afirst), 64'((SMAX + 1) * (MW + 1)));
        check("t6_cpu_rdata", 64'(w_rdata), 64'hE1);
        check("t6_video_total", 64'(w_valid),
              64'(((MW + 1) * (SMAX + 4) + 3) / (MW + 1) - 1));
`else
        check("t6_cpu_starved", 64'(w_ack), 64'd0);
        check("t6_video_total", 64'(w_valid),
              64'(((MW + 1) * (SMAX + 4) + 3) / (MW + 1)));
        check("t6_vid_data", 64'(w_vdata), 64'h66);
`endif
        vid_req = 1'b0;
        cpu_req = 1'b0;
        tick(2 * (MW + 1) + 2);

        // Random traffic from both requesters.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = $urandom;
            poke(8'(i), r[7:0]);
            ref_mem[i] = r[7:0];
        end
        fork
            vid_proc();
            cpu_proc();
        join
        tick(4);

        stop_mon = 1'b1;
        tick(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
